pipeline_sequencer: RTL and testbench

Parametrised N-stage sequencer for the CNN inference pipeline (conv, relu, pool, flat, dense, tx and any added layers). A frame trigger launches the enabled stages strictly in index order, one at a time. Each stage gets a one-cycle start pulse and runs until its done flag. Adds over the fixed controller: runtime stage bypass, per-stage launch gating, a per-stage timeout watchdog with error capture, abort, and a frame counter.

---
 rtl/pipeline_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Runs the enabled stages of the CNN inference pipeline one at a
//            time, in index order, once per frame trigger. Each stage gets a
//            one-cycle start pulse (unless it starts itself) and is then
//            watched until its done flag. Stages can be bypassed at runtime
//            and held off by a per-stage ready gate. A per-stage watchdog
//            captures a sticky error, and abort returns to idle. Completed
//            frames are counted.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            i_frame_loaded        - frame trigger, sampled only in IDLE
//            i_stage_en[N]         - bypass mask, captured on trigger
//            i_stage_ready[N]      - launch gate per stage
//            i_stage_done[N]       - completion flag per stage
//            i_abort               - return to IDLE from any busy state
//            i_clear_error         - clear sticky error / leave ERROR
//            o_stage_start[N]      - one-cycle start pulses (one-hot or 0)
//            o_busy                - high in every state except IDLE
//            o_active_stage        - index of the current stage
//            o_frame_done          - one-cycle pulse on frame completion
//            o_error, o_err_stage  - sticky watchdog error and its stage
//            o_frame_count         - completed frames, wraps
//            o_last_frame_cycles   - (SEQ_PERF_CNT_EN only) cycles of the
//                                    last completed frame
// Options  : define SEQ_PERF_CNT_EN to add the frame cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int                    NUM_STAGES     = 6,
    parameter logic [NUM_STAGES-1:0] START_MASK     = 6'b101111,
    parameter int                    TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = 24'd1_000_000,
    parameter int                    FRAME_CNT_W    = 16,
    localparam int                   IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_frame_loaded,
    input  logic [NUM_STAGES-1:0]  i_stage_en,
    input  logic [NUM_STAGES-1:0]  i_stage_ready,
    input  logic [NUM_STAGES-1:0]  i_stage_done,
    input  logic                   i_abort,
    input  logic                   i_clear_error,
    output logic [NUM_STAGES-1:0]  o_stage_start,
    output logic                   o_busy,
    output logic [IDX_W-1:0]       o_active_stage,
    output logic                   o_frame_done,
    output logic                   o_error,
    output logic [IDX_W-1:0]       o_err_stage,
    output logic [FRAME_CNT_W-1:0] o_frame_count
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            o_last_frame_cycles
`endif
);

    localparam logic                 c_WDOG_EN      = (TIMEOUT_CYCLES != '0);
    localparam logic [TIMEOUT_W-1:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [NUM_STAGES-1:0]  r_en_q;
    logic [TIMEOUT_W-1:0]   r_timer;
    logic [IDX_W-1:0]       r_active;
    logic [NUM_STAGES-1:0]  r_start;
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_error;
    logic [IDX_W-1:0]       r_err_stage;
    logic [FRAME_CNT_W-1:0] r_fc;

    state_t                 w_state_nxt;
    logic [NUM_STAGES-1:0]  w_en_nxt;
    logic [TIMEOUT_W-1:0]   w_timer_nxt;
    logic [IDX_W-1:0]       w_active_nxt;
    logic [NUM_STAGES-1:0]  w_start_nxt;
    logic                   w_frame_done_nxt;
    logic                   w_error_nxt;
    logic [IDX_W-1:0]       w_err_stage_nxt;
    logic [FRAME_CNT_W-1:0] w_fc_nxt;

    // {found, index} of the lowest set bit of mask; when strict is set only
    // bits strictly above 'from' are considered.
    function automatic logic [IDX_W:0] f_scan(input logic [NUM_STAGES-1:0] mask,
                                              input logic [IDX_W-1:0]      from,
                                              input logic                  strict);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (mask[i] && (!strict || (IDX_W'(i) > from))) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    logic [IDX_W:0] w_first;
    logic [IDX_W:0] w_next;

    assign w_first = f_scan(i_stage_en, '0, 1'b0);
    assign w_next  = f_scan(r_en_q, r_active, 1'b1);

    always_comb begin
        w_state_nxt      = r_state;
        w_en_nxt         = r_en_q;
        w_timer_nxt      = r_timer;
        w_active_nxt     = r_active;
        w_start_nxt      = '0;
        w_frame_done_nxt = 1'b0;
        w_error_nxt      = r_error & ~i_clear_error;
        w_err_stage_nxt  = r_err_stage;
        w_fc_nxt         = r_fc;

        case (r_state)
            S_IDLE: begin
                if (i_frame_loaded) begin
                    w_en_nxt = i_stage_en;
                    if (w_first[IDX_W]) begin
                        w_active_nxt = w_first[IDX_W-1:0];
                        w_state_nxt  = S_LAUNCH;
                    end else begin
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_LAUNCH: begin
                if (i_stage_ready[r_active]) begin
                    // Self-started stages get no pulse; we only wait on done.
                    w_start_nxt[r_active] = START_MASK[r_active];
                    w_timer_nxt           = '0;
                    w_state_nxt           = S_RUN;
                end
            end
            S_RUN: begin
                // Done is checked before the watchdog so that it wins a tie.
                if (i_stage_done[r_active]) begin
                    if (w_next[IDX_W]) begin
                        w_active_nxt = w_next[IDX_W-1:0];
                        w_state_nxt  = S_LAUNCH;
                    end else begin
                        w_state_nxt  = S_DONE;
                    end
                end else if (c_WDOG_EN && (r_timer == c_TIMEOUT_LAST)) begin
                    w_error_nxt     = 1'b1;
                    w_err_stage_nxt = r_active;
                    w_state_nxt     = S_ERROR;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_DONE: begin
                w_frame_done_nxt = 1'b1;
                w_fc_nxt         = r_fc + 1'b1;
                w_state_nxt      = S_IDLE;
            end
            S_ERROR: begin
                if (i_clear_error) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything except the idle trigger; a timeout in
        // the same cycle is discarded, an existing error is kept.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_nxt      = S_IDLE;
            w_start_nxt      = '0;
            w_frame_done_nxt = 1'b0;
            w_fc_nxt         = r_fc;
            w_timer_nxt      = r_timer;
            w_error_nxt      = r_error & ~i_clear_error;
            w_err_stage_nxt  = r_err_stage;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_en_q       <= '0;
            r_timer      <= '0;
            r_active     <= '0;
            r_start      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            r_err_stage  <= '0;
            r_fc         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_en_q       <= w_en_nxt;
            r_timer      <= w_timer_nxt;
            r_active     <= w_active_nxt;
            r_start      <= w_start_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_frame_done_nxt;
            r_error      <= w_error_nxt;
            r_err_stage  <= w_err_stage_nxt;
            r_fc         <= w_fc_nxt;
        end
    end

    assign o_stage_start  = r_start;
    assign o_busy         = r_busy;
    assign o_active_stage = r_active;
    assign o_frame_done   = r_frame_done;
    assign o_error        = r_error;
    assign o_err_stage    = r_err_stage;
    assign o_frame_count  = r_fc;

`ifdef SEQ_PERF_CNT_EN
    // Counts cycles from the trigger edge up to and including DONE.
    logic [31:0] r_cyc;
    logic [31:0] r_last_cyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc      <= '0;
            r_last_cyc <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_frame_loaded) begin
                r_cyc <= 32'd1;
            end else if (r_state != S_IDLE) begin
                r_cyc <= r_cyc + 32'd1;
            end
            if ((r_state == S_DONE) && !i_abort) begin
                r_last_cyc <= r_cyc;
            end
        end
    end

    assign o_last_frame_cycles = r_last_cyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Directed self-checking bench for pipeline_sequencer (6 stages,
//            stage 4 self-started, watchdog limit 8 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_frame_loaded;
    logic [5:0]  i_stage_en;
    logic [5:0]  i_stage_ready;
    logic [5:0]  i_stage_done;
    logic        i_abort;
    logic        i_clear_error;
    logic [5:0]  o_stage_start;
    logic        o_busy;
    logic [2:0]  o_active_stage;
    logic        o_frame_done;
    logic        o_error;
    logic [2:0]  o_err_stage;
    logic [15:0] o_frame_count;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] o_last_frame_cycles;
`endif

    pipeline_sequencer #(
        .NUM_STAGES     (6),
        .START_MASK     (6'b101111),
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (24'd8),
        .FRAME_CNT_W    (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_frame_loaded (i_frame_loaded),
        .i_stage_en     (i_stage_en),
        .i_stage_ready  (i_stage_ready),
        .i_stage_done   (i_stage_done),
        .i_abort        (i_abort),
        .i_clear_error  (i_clear_error),
        .o_stage_start  (o_stage_start),
        .o_busy         (o_busy),
        .o_active_stage (o_active_stage),
        .o_frame_done   (o_frame_done),
        .o_error        (o_error),
        .o_err_stage    (o_err_stage),
        .o_frame_count  (o_frame_count)
`ifdef SEQ_PERF_CNT_EN
        ,
        .o_last_frame_cycles (o_last_frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;

    // Stage responder: pulse done 3 cycles after a start pulse, unless the
    // stage is hung; lvl holds done high permanently (self-started stage).
    logic [5:0] resp = '0;
    logic [5:0] lvl  = '0;
    logic [5:0] hang = '0;
    int         rcnt [6];
    assign i_stage_done = resp | lvl;

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            logic w;
            w = (rcnt[i] == 1) && !hang[i];
            if (rcnt[i] > 0) rcnt[i] = rcnt[i] - 1;
            if (o_stage_start[i]) rcnt[i] = 3;
            resp[i] = w;
        end
    end

    // Observations from one frame run.
    int         seqcode;
    int         npulse;
    int         n_fd;
    int         fd_cycle;
    bit         multi;
    bit         tmo;
    bit         busy_at_fd;
    logic [5:0] visited;

    task automatic run_frame(input logic [5:0] en);
        int n;
        seqcode = 0; npulse = 0; n_fd = 0; fd_cycle = -1;
        multi = 0; tmo = 0; busy_at_fd = 1; visited = '0;
        i_stage_en     = en;
        i_frame_loaded = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (n == 1) i_frame_loaded = 1'b0;
            if ($countones(o_stage_start) > 1) multi = 1;
            for (int i = 0; i < 6; i++) begin
                if (o_stage_start[i]) begin
                    seqcode = seqcode * 10 + i + 1;
                    npulse++;
                end
            end
            if (o_busy) visited[o_active_stage] = 1'b1;
            if (o_frame_done) begin
                n_fd++;
                if (fd_cycle < 0) begin
                    fd_cycle   = n;
                    busy_at_fd = o_busy;
                end
            end
            if (fd_cycle >= 0 && n >= fd_cycle + 3) break;
            if (n >= 400) begin tmo = 1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        i_frame_loaded = 0; i_stage_en = 0; i_stage_ready = 6'h3F;
        i_abort = 0; i_clear_error = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({o_stage_start, o_busy, o_active_stage, o_frame_done, o_error, o_err_stage} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got start=%b busy=%b act=%0d fd=%b err=%b es=%0d, expected all 0",
                     o_stage_start, o_busy, o_active_stage, o_frame_done, o_error, o_err_stage);
        end
        total++;
        if (o_frame_count !== 16'd0) begin
            bad++; $display("FAIL reset_count: got %0d expected 0", o_frame_count);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_all_stages;
        lvl = 6'b010000; hang = '0; i_stage_ready = 6'h3F;
        run_frame(6'h3F);
        exp_fc++;
        total++;
        if (tmo) begin bad++; $display("FAIL all_timeout: no frame_done within budget"); end
        total++;
        if (seqcode != 12346) begin
            bad++; $display("FAIL all_start_order: got code %0d expected 12346 (stages 0,1,2,3,5)", seqcode);
        end
        total++;
        if (multi) begin bad++; $display("FAIL all_onehot: got multi-bit start, expected one-hot"); end
        total++;
        if (n_fd != 1) begin bad++; $display("FAIL all_frame_done: got %0d pulses expected 1", n_fd); end
        total++;
        if (o_frame_count !== 16'(exp_fc)) begin
            bad++; $display("FAIL all_count: got %0d expected %0d", o_frame_count, exp_fc);
        end
        total++;
        if (busy_at_fd !== 1'b0) begin
            bad++; $display("FAIL all_busy_at_fd: got %b expected 0", busy_at_fd);
        end
    endtask

    task automatic test_bypass;
        lvl = 6'b010000; hang = '0; i_stage_ready = 6'h3F;
        run_frame(6'b100101);
        exp_fc++;
        total++;
        if (seqcode != 136) begin
            bad++; $display("FAIL bypass_order: got code %0d expected 136 (stages 0,2,5)", seqcode);
        end
        total++;
        if (visited !== 6'b100101) begin
            bad++; $display("FAIL bypass_visited: got %b expected 100101", visited);
        end
        total++;
        if (n_fd != 1 || o_frame_count !== 16'(exp_fc)) begin
            bad++; $display("FAIL bypass_done: got fd=%0d cnt=%0d expected 1 and %0d", n_fd, o_frame_count, exp_fc);
        end
    endtask

    task automatic test_empty;
        lvl = 6'b010000; hang = '0; i_stage_ready = 6'h3F;
        run_frame(6'h00);
        exp_fc++;
        total++;
        if (fd_cycle != 2) begin
            bad++; $display("FAIL empty_latency: got %0d cycles expected 2", fd_cycle);
        end
        total++;
        if (npulse != 0) begin bad++; $display("FAIL empty_starts: got %0d pulses expected 0", npulse); end
        total++;
        if (n_fd != 1 || o_frame_count !== 16'(exp_fc)) begin
            bad++; $display("FAIL empty_done: got fd=%0d cnt=%0d expected 1 and %0d", n_fd, o_frame_count, exp_fc);
        end
    endtask

    task automatic test_min_len;
        lvl = 6'h3F; hang = '0; i_stage_ready = 6'h3F;
        run_frame(6'h3F);
        exp_fc++;
        lvl = 6'b010000;
        total++;
        if (fd_cycle != 14) begin
            bad++; $display("FAIL minlen_latency: got %0d cycles expected 14", fd_cycle);
        end
        total++;
        if (o_frame_count !== 16'(exp_fc)) begin
            bad++; $display("FAIL minlen_count: got %0d expected %0d", o_frame_count, exp_fc);
        end
`ifdef SEQ_PERF_CNT_EN
        total++;
        if (o_last_frame_cycles !== 32'd13) begin
            bad++; $display("FAIL perf_cycles: got %0d expected 13", o_last_frame_cycles);
        end
`endif
    endtask

    task automatic test_ready_gate;
        int n;
        int p5;
        bit fd;
        lvl = 6'b010000; hang = '0; i_stage_ready = 6'b011111;
        i_stage_en = 6'h3F; i_frame_loaded = 1'b1;
        n = 0; p5 = 0; fd = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) i_frame_loaded = 1'b0;
            if (o_stage_start[5]) p5++;
        end while (!(o_busy && o_active_stage == 3'd5) && n < 200);
        total++;
        if (n >= 200) begin bad++; $display("FAIL gate_reach5: stage 5 not reached within budget"); end
        repeat (10) begin
            @(negedge clk);
            if (o_stage_start[5]) p5++;
        end
        total++;
        if (p5 != 0) begin bad++; $display("FAIL gate_held: got %0d pulses on stage 5 expected 0", p5); end
        i_stage_ready = 6'h3F;
        for (int k = 0; k < 50 && !fd; k++) begin
            @(negedge clk);
            if (o_stage_start[5]) p5++;
            if (o_frame_done) fd = 1;
        end
        exp_fc++;
        total++;
        if (p5 != 1 || !fd) begin
            bad++; $display("FAIL gate_release: got pulses=%0d fd=%0b expected 1 and 1", p5, fd);
        end
        total++;
        if (o_frame_count !== 16'(exp_fc)) begin
            bad++; $display("FAIL gate_count: got %0d expected %0d", o_frame_count, exp_fc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        bit early;
        lvl = 6'b010000; hang = 6'b000100; i_stage_ready = 6'h3F;
        for (int it = 0; it < 2; it++) begin
            i_stage_en = 6'h3F; i_frame_loaded = 1'b1; n = 0; early = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) i_frame_loaded = 1'b0;
            end while (!o_stage_start[2] && n < 100);
            total++;
            if (n >= 100) begin bad++; $display("FAIL tmo_start2: stage 2 never started"); end
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (k < 8 && o_error) early = 1;
            end
            total++;
            if (early) begin bad++; $display("FAIL tmo_early: got error before 8 RUN cycles expected none"); end
            total++;
            if (o_error !== 1'b1 || o_err_stage !== 3'd2 || o_busy !== 1'b1) begin
                bad++; $display("FAIL tmo_capture: got err=%b stage=%0d busy=%b expected 1, 2, 1",
                                o_error, o_err_stage, o_busy);
            end
            i_frame_loaded = 1'b1;
            early = 0;
            repeat (3) begin
                @(negedge clk);
                if (o_stage_start !== 6'd0 || o_busy !== 1'b1 || o_error !== 1'b1) early = 1;
            end
            i_frame_loaded = 1'b0;
            total++;
            if (early) begin bad++; $display("FAIL tmo_ignore_trigger: got activity in ERROR expected none"); end
            if (it == 0) begin
                i_clear_error = 1'b1;
                @(negedge clk);
                i_clear_error = 1'b0;
                total++;
                if (o_error !== 1'b0 || o_busy !== 1'b0 || o_err_stage !== 3'd2) begin
                    bad++; $display("FAIL tmo_clear: got err=%b busy=%b stage=%0d expected 0, 0, 2",
                                    o_error, o_busy, o_err_stage);
                end
            end else begin
                i_abort = 1'b1;
                @(negedge clk);
                i_abort = 1'b0;
                total++;
                if (o_busy !== 1'b0 || o_error !== 1'b1) begin
                    bad++; $display("FAIL tmo_abort: got busy=%b err=%b expected 0 and 1", o_busy, o_error);
                end
                i_clear_error = 1'b1;
                @(negedge clk);
                i_clear_error = 1'b0;
                total++;
                if (o_error !== 1'b0) begin
                    bad++; $display("FAIL tmo_abort_clear: got err=%b expected 0", o_error);
                end
            end
            total++;
            if (o_frame_count !== 16'(exp_fc)) begin
                bad++; $display("FAIL tmo_count: got %0d expected %0d", o_frame_count, exp_fc);
            end
        end
        hang = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort;
        int n;
        bit stray;
        lvl = 6'b010000; hang = '0; i_stage_ready = 6'h3F;
        i_stage_en = 6'h3F; i_frame_loaded = 1'b1; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) i_frame_loaded = 1'b0;
        end while (!o_stage_start[3] && n < 100);
        total++;
        if (n >= 100) begin bad++; $display("FAIL abort_start3: stage 3 never started"); end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_stage_start !== 6'd0 || o_frame_count !== 16'(exp_fc)) begin
            bad++; $display("FAIL abort_idle: got busy=%b start=%b cnt=%0d expected 0, 0, %0d",
                            o_busy, o_stage_start, o_frame_count, exp_fc);
        end
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_frame_done || o_busy) stray = 1;
        end
        total++;
        if (stray) begin bad++; $display("FAIL abort_quiet: got frame_done/busy after abort expected none"); end
        run_frame(6'h3F);
        exp_fc++;
        total++;
        if (seqcode != 12346 || n_fd != 1 || o_frame_count !== 16'(exp_fc)) begin
            bad++; $display("FAIL abort_rerun: got code=%0d fd=%0d cnt=%0d expected 12346, 1, %0d",
                            seqcode, n_fd, o_frame_count, exp_fc);
        end
    endtask

    task automatic test_reset_mid;
        bit stray;
        lvl = 6'b010000; hang = '0; i_stage_ready = 6'h3F;
        i_stage_en = 6'h3F; i_frame_loaded = 1'b1;
        @(negedge clk);
        i_frame_loaded = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_frame_count !== 16'd0 || o_stage_start !== 6'd0) begin
            bad++; $display("FAIL midreset: got busy=%b cnt=%0d start=%b expected 0, 0, 0",
                            o_busy, o_frame_count, o_stage_start);
        end
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_frame_done || o_busy) stray = 1;
        end
        total++;
        if (stray) begin bad++; $display("FAIL midreset_quiet: got activity after reset expected none"); end
    endtask

    initial begin
        test_reset();
        test_all_stages();
        test_bypass();
        test_empty();
        test_min_len();
        test_ready_gate();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
